// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional skid entry, hazard freeze, branch flush
// and saturating stall/flush performance counters.
module pipe_stage_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter bit                 SKID      = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic               main_valid_q, main_valid_d;
  logic [PC_W-1:0]    main_pc_q,    main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic               skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q,  flush_cnt_d;

  logic in_fire;
  logic out_fire;
  logic stall_evt;

  assign out_valid = main_valid_q & ~freeze & ~flush;
  assign in_ready  = (SKID ? ~skid_valid_q : (~main_valid_q | out_ready)) & ~freeze & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign stall_evt = freeze | (main_valid_q & ~out_ready);

  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Skid always drains into main before any newer beat, which keeps program order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_pc_d    = '0;
      main_instr_d = NOP_INSTR;
    end else if (!freeze) begin
      if (!main_valid_q || out_fire) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_pc_d    = skid_pc_q;
          main_instr_d = skid_instr_q;
          skid_valid_d = SKID && in_fire;
          if (SKID && in_fire) begin
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
          end
        end else if (in_fire) begin
          main_valid_d = 1'b1;
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (SKID && in_fire) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = in_pc;
        skid_instr_d = in_instr;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule
